uart_rx_frontend: RTL and testbench

//   8N1 UART receiver feeding the system's serial input path (com_RxD). It

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_frontend.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
//   Byte hand-off between the UART receive front end and the host-I/O logic.
//   rx_data  : received byte, LSB received first
//   rx_valid : rx_data holds an unconsumed byte
//   rx_ready : consumer accepts the byte when rx_valid && rx_ready
//   master   : the receiver (drives rx_data/rx_valid, observes rx_ready)
//   slave    : the consumer (observes rx_data/rx_valid, drives rx_ready)
// ----------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// ----------------------------------------------------------------------------
// uart_rx_frontend
//   8N1 UART receiver with 16x (parameterisable) oversampling. The RxD pin is
//   brought into the clock domain through two flops; the frame is sampled at
//   mid-bit and completed bytes are handed out through a one-entry
//   valid/ready buffer. Framing errors and overruns are one-cycle pulses.
//
//   Parameters:
//     CLK_FREQ   system clock in Hz
//     BAUD       line rate in bit/s
//     OVERSAMPLE samples per bit (even, >= 8)
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     rxd        asynchronous serial input, idle-high
//     rx_bus     byte hand-off (uart_rx_if.master: rx_data, rx_valid, rx_ready)
//     frame_err  one-cycle pulse: stop bit sampled low
//     overrun    one-cycle pulse: byte completed while buffer still full
//     busy       high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_frontend #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    uart_rx_if.master   rx_bus,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int PR_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SC_W = $clog2(OVERSAMPLE);

    localparam logic [PR_W-1:0] PR_LAST = PR_W'(DIV - 1);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_rx_frontend: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
            $error("uart_rx_frontend: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic            rxd_meta;
    logic            rxd_s;
    logic [PR_W-1:0] presc;
    logic [SC_W-1:0] sc;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tick;

    // The prescaler is held at zero in IDLE, so the first tick of a frame
    // lands exactly DIV clocks after the start edge was seen.
    assign tick = (presc == PR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta        <= 1'b1;
            rxd_s           <= 1'b1;
            state           <= IDLE;
            presc           <= '0;
            sc              <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            rx_bus.rx_data  <= 8'h00;
            rx_bus.rx_valid <= 1'b0;
            frame_err       <= 1'b0;
            overrun         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            rxd_meta  <= rxd;
            rxd_s     <= rxd_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer drain; a byte loaded below in the same cycle wins.
            if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                rx_bus.rx_valid <= 1'b0;
            end

            if (state == IDLE) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        sc      <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sc == SC_MID) begin
                            // Mid start bit: a high line means it was a glitch.
                            sc <= '0;
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc      <= '0;
                            shreg   <= {rxd_s, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc <= '0;
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
                                    rx_bus.rx_data  <= shreg;
                                    rx_bus.rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line returns high so a long low
                    // period is not taken as a stream of start bits.
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frontend
//   Drives serial frames into uart_rx_frontend at a reduced clock/baud ratio
//   (8 clk per sample, 128 clk per bit) and checks delivered bytes against an
//   expected-byte queue, plus flags, busy and reset behaviour.
// ----------------------------------------------------------------------------
module tb_uart_rx_frontend;

    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 93_750;
    localparam int OS       = 16;
    localparam int BIT      = CLK_FREQ / BAUD;      // clocks per bit
    localparam int LAT      = (19 * BIT) / 2 + 3;   // 9.5 bit times + 3 clk

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_if bus ();

    uart_rx_frontend #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_bus    (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_valid_hi;
    int         n_accept;
    int         n_ferr;
    int         n_ovr;
    int         first_valid_cyc;
    int         start_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid_hi      = 0;
        n_accept        = 0;
        n_ferr          = 0;
        n_ovr           = 0;
        first_valid_cyc = -1;
    endtask

    // Stimulus is applied 1 time unit after the rising edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; leaves rxd at
    // the stop-bit level.
    task automatic send_raw(input logic [7:0] b, input logic stop);
        rxd       = 1'b0;
        start_cyc = cyc;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(BIT);
        end
        rxd = stop;
        wait_clk(BIT);
    endtask

    // A well-formed frame with the consumer ready is expected to arrive intact.
    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        send_raw(b, 1'b1);
        rxd = 1'b1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every
    // accepted byte and tallies flag pulses.
    initial begin
        logic       prev_valid;
        logic       prev_acc;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_acc   = 1'b0;
            end else begin
                if (bus.rx_valid) begin
                    n_valid_hi++;
                    if (!prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (prev_valid && !prev_acc && bus.rx_valid)
                    chk("rx_data_stable", {24'h0, bus.rx_data}, {24'h0, prev_data});
                if (bus.rx_valid && bus.rx_ready) begin
                    n_accept++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no delivery", bus.rx_data);
                    end else begin
                        chk("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
                    end
                end
                if (frame_err) n_ferr++;
                if (overrun)   n_ovr++;
                if (frame_err || overrun)
                    chk("flags_exclusive", {31'h0, frame_err & overrun}, 32'h0);
                prev_valid = bus.rx_valid;
                prev_acc   = bus.rx_valid && bus.rx_ready;
                prev_data  = bus.rx_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        logic [7:0] rb;

        bus.rx_ready = 1'b1;
        clear_stats();
        wait_clk(5);

        // Reset values
        chk("rst_busy",      {31'h0, busy},         32'h0);
        chk("rst_rx_valid",  {31'h0, bus.rx_valid}, 32'h0);
        chk("rst_rx_data",   {24'h0, bus.rx_data},  32'h0);
        chk("rst_frame_err", {31'h0, frame_err},    32'h0);
        chk("rst_overrun",   {31'h0, overrun},      32'h0);
        rst = 1'b0;
        wait_clk(BIT);

        // 1: single byte, latency and one-cycle valid pulse
        clear_stats();
        send_byte(8'h55);
        wait_clk(BIT);
        diff = first_valid_cyc - start_cyc;
        n_cmp++;
        if (first_valid_cyc < 0 || diff < LAT - 4 || diff > LAT + 4) begin
            n_err++;
            $display("FAIL t1_latency: got %0d clk, expected %0d +/-4", diff, LAT);
        end
        chk("t1_valid_cycles", n_valid_hi,   1);
        chk("t1_frame_err",    n_ferr,       0);
        chk("t1_overrun",      n_ovr,        0);
        chk("t1_pending",      exp_q.size(), 0);

        // 2: short low glitch is a false start
        clear_stats();
        rxd = 1'b0;
        wait_clk(10);
        chk("t2_busy_rise", {31'h0, busy}, 32'h1);
        wait_clk(BIT / 3 - 10);
        rxd = 1'b1;
        wait_clk(BIT);
        chk("t2_busy_fall",   {31'h0, busy}, 32'h0);
        chk("t2_valid",       n_valid_hi,    0);
        chk("t2_frame_err",   n_ferr,        0);

        // 3: bad stop bit, line held low afterwards
        clear_stats();
        send_raw(8'hA3, 1'b0);
        wait_clk(2 * BIT);
        chk("t3_frame_err",   n_ferr,        1);
        chk("t3_valid",       n_valid_hi,    0);
        chk("t3_break_busy",  {31'h0, busy}, 32'h1);
        rxd = 1'b1;
        wait_clk(5);
        chk("t3_idle_busy",   {31'h0, busy}, 32'h0);
        wait_clk(BIT);

        // 4: overrun with consumer stalled
        clear_stats();
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'h12);
        send_raw(8'h12, 1'b1);
        send_raw(8'h34, 1'b1);
        wait_clk(BIT);
        chk("t4_overrun",   n_ovr,                 1);
        chk("t4_frame_err", n_ferr,                0);
        chk("t4_rx_valid",  {31'h0, bus.rx_valid}, 32'h1);
        chk("t4_rx_data",   {24'h0, bus.rx_data},  32'h12);
        bus.rx_ready = 1'b1;
        wait_clk(1);
        bus.rx_ready = 1'b0;
        chk("t4_drained",   {31'h0, bus.rx_valid}, 32'h0);
        chk("t4_accepts",   n_accept,              1);
        chk("t4_pending",   exp_q.size(),          0);
        bus.rx_ready = 1'b1;
        wait_clk(BIT);

        // 5: reset in the middle of the data bits
        clear_stats();
        rb  = 8'h5A;
        rxd = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 3; i++) begin
            rxd = rb[i];
            wait_clk(BIT);
        end
        rst = 1'b1;
        rxd = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("t5_busy",      {31'h0, busy},         32'h0);
        chk("t5_rx_valid",  {31'h0, bus.rx_valid}, 32'h0);
        chk("t5_rx_data",   {24'h0, bus.rx_data},  32'h0);
        chk("t5_frame_err", {31'h0, frame_err},    32'h0);
        chk("t5_overrun",   {31'h0, overrun},      32'h0);
        wait_clk(2 * BIT);
        send_byte(8'hC9);
        wait_clk(BIT);
        chk("t5_accepts",   n_accept,     1);
        chk("t5_pending",   exp_q.size(), 0);
        chk("t5_flags",     n_ferr + n_ovr, 0);

        // 6: back-to-back frames with no idle gap
        clear_stats();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h80);
        wait_clk(BIT);
        chk("t6_accepts", n_accept,       3);
        chk("t6_pending", exp_q.size(),   0);
        chk("t6_flags",   n_ferr + n_ovr, 0);

        // Random bytes with random idle gaps
        clear_stats();
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb);
            wait_clk(1 + $urandom_range(0, BIT));
        end
        wait_clk(BIT);
        chk("rnd_accepts", n_accept,       8);
        chk("rnd_pending", exp_q.size(),   0);
        chk("rnd_flags",   n_ferr + n_ovr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
